// File: rtl/noc_packet_accumulator.sv
// Purpose : NoC reduction endpoint; sums every beat of a TLAST-delimited packet
//           and injects the total as a single-beat packet toward DEST_ADDR.
// Latency : result TVALID rises one cycle after the closing beat is accepted;
//           an N-beat packet occupies N+1 cycles minimum.
// Backpressure: while the result waits for AXIS_M_TREADY, AXIS_S_TREADY is held
//           low, so incoming beats stall rather than merge into the next packet.
//
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   AXIS_S_*             slave stream from the mesh router output (TDEST ignored)
//   AXIS_M_*             master stream into the mesh router input
//   SUM_O / OVF_O        total and carry flag of the last result taken downstream
//   PKT_COUNT_O          number of result packets sent (wraps)
//   TRUNC_O              sticky: some packet was closed early at MAX_BEATS
//   BUSY                 high while accumulating or sending
module noc_packet_accumulator #(
   parameter int                TDATAW    = 32,
   parameter int                TDESTW    = 4,
   parameter logic [TDESTW-1:0] DEST_ADDR = TDESTW'(3),
   parameter int                MAX_BEATS = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TDESTW-1:0] AXIS_M_TDEST,
   output logic [TDATAW-1:0] SUM_O,
   output logic [15:0]       PKT_COUNT_O,
   output logic              OVF_O,
   output logic              TRUNC_O,
   output logic              BUSY
);

   localparam int BW = $clog2(MAX_BEATS + 1);
   localparam logic [BW-1:0] MAX_B    = BW'(MAX_BEATS);
   localparam bit            ONE_BEAT = (MAX_BEATS == 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [TDATAW-1:0] acc;
   logic [TDATAW-1:0] acc_nxt;
   logic              ovf;
   logic              ovf_nxt;
   logic [BW-1:0]     beats;
   logic [BW-1:0]     beats_inc;
   logic [TDATAW:0]   sum_ext;
   logic              s_hs;
   logic              m_hs;
   logic              force_close;

   // Incoming destination is meaningless at an endpoint.
   logic unused_tdest;
   assign unused_tdest = ^AXIS_S_TDEST;

   assign s_hs      = AXIS_S_TVALID & AXIS_S_TREADY;
   assign m_hs      = AXIS_M_TVALID & AXIS_M_TREADY;
   assign beats_inc = beats + 1'b1;
   assign sum_ext   = {1'b0, acc} + {1'b0, AXIS_S_TDATA};

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      ovf_nxt     = ovf;
      force_close = 1'b0;
      case (state)
         IDLE: begin
            if (s_hs) begin
               acc_nxt     = AXIS_S_TDATA;
               ovf_nxt     = 1'b0;
               force_close = ONE_BEAT && !AXIS_S_TLAST;
               state_nxt   = (AXIS_S_TLAST || ONE_BEAT) ? SEND : ACCUM;
            end
         end
         ACCUM: begin
            if (s_hs) begin
               acc_nxt     = sum_ext[TDATAW-1:0];
               ovf_nxt     = ovf | sum_ext[TDATAW];
               force_close = (beats_inc == MAX_B) && !AXIS_S_TLAST;
               if (AXIS_S_TLAST || beats_inc == MAX_B) begin
                  state_nxt = SEND;
               end
            end
         end
         SEND: begin
            if (m_hs) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         acc           <= '0;
         ovf           <= 1'b0;
         beats         <= '0;
         AXIS_S_TREADY <= 1'b0;
         AXIS_M_TVALID <= 1'b0;
         AXIS_M_TDATA  <= '0;
         AXIS_M_TLAST  <= 1'b0;
         AXIS_M_TDEST  <= '0;
         SUM_O         <= '0;
         PKT_COUNT_O   <= '0;
         OVF_O         <= 1'b0;
         TRUNC_O       <= 1'b0;
         BUSY          <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         ovf   <= ovf_nxt;
         if (s_hs) begin
            beats <= (state == IDLE) ? BW'(1) : beats_inc;
         end
         if (force_close) begin
            TRUNC_O <= 1'b1;
         end

         // Ready is a flop fed from next state, so it never combinationally
         // follows AXIS_M_TREADY; low only while a result is outstanding.
         AXIS_S_TREADY <= (state_nxt != SEND);
         BUSY          <= (state_nxt != IDLE);

         if (state != SEND && state_nxt == SEND) begin
            AXIS_M_TVALID <= 1'b1;
            AXIS_M_TDATA  <= acc_nxt;
            AXIS_M_TLAST  <= 1'b1;
            AXIS_M_TDEST  <= DEST_ADDR;
         end else if (m_hs) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            AXIS_M_TDEST  <= '0;
            SUM_O         <= acc;
            OVF_O         <= ovf;
            PKT_COUNT_O   <= PKT_COUNT_O + 16'd1;
         end
      end
   end

endmodule
